// File: rtl/dm_arbiter_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// State encoding and address range check used by both requesters.
package dm_arbiter_pkg;

  typedef enum logic [1:0] {
    CPU_PRI = 2'd0,
    DMA_OWN = 2'd1
  } arb_state_e;

  localparam int unsigned DM_WORDS_DEF = 3072;
  localparam int unsigned DM_BYTES = 4 * DM_WORDS_DEF;

  function automatic logic in_range(
    input logic [31:0] addr,
    input logic [31:0] lim
  );
    return addr < lim;
  endfunction

endpackage

// File: rtl/dm_arbiter_fsm.sv
// Ownership FSM for the DM arbiter: CPU priority, starvation
// counter forcing a DMA grant, and a burst lock for DMA beats.
module dm_arbiter_fsm
  import dm_arbiter_pkg::*;
#(
  parameter int MAX_WAIT  = 4,
  parameter int BURST_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic cpu_req,
  input  logic dma_valid,
  output logic grant_cpu,
  output logic grant_dma
);

  localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);
  localparam logic [3:0] BEAT_LIM = 4'(BURST_MAX - 1);
  localparam logic       LOCK_ON  = (BURST_MAX > 1);

  arb_state_e state, state_n;
  logic [3:0] wait_cnt, wait_n;
  logic [3:0] beat_cnt, beat_n;

  // State and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= CPU_PRI;
      wait_cnt <= 4'd0;
      beat_cnt <= 4'd0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_n;
      beat_cnt <= beat_n;
    end
  end

  // Grants, next state and counter updates
  always_comb begin
    state_n   = state;
    wait_n    = wait_cnt;
    beat_n    = beat_cnt;
    grant_dma = 1'b0;
    grant_cpu = 1'b0;
    unique case (state)
      CPU_PRI: begin
        grant_dma = dma_valid &
                    (!cpu_req | (wait_cnt == WAIT_LIM));
        grant_cpu = cpu_req & !grant_dma;
        if (grant_dma || !dma_valid)
          wait_n = 4'd0;
        else if (wait_cnt != WAIT_LIM)
          wait_n = wait_cnt + 4'd1;
        if (grant_dma && LOCK_ON) begin
          state_n = DMA_OWN;
          beat_n  = 4'd1;
        end
      end
      DMA_OWN: begin
        grant_dma = dma_valid;
        if (!dma_valid || beat_cnt == BEAT_LIM) begin
          state_n = CPU_PRI;
          beat_n  = 4'd0;
          wait_n  = 4'd0;
        end else begin
          beat_n = beat_cnt + 4'd1;
        end
      end
      default: begin
        state_n = CPU_PRI;
        beat_n  = 4'd0;
        wait_n  = 4'd0;
      end
    endcase
  end

endmodule

// File: rtl/dm_arbiter.sv
// Data-memory arbiter between the M stage and a DMA port.
// Drives the DM address/data/we and returns DMA responses.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int MAX_WAIT  = 4,
  parameter int BURST_MAX = 4,
  parameter int DM_WORDS  = DM_WORDS_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_valid,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_ready,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
  output logic        dma_err,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic        dm_we,
  input  logic [31:0] dm_rd
);

  localparam logic [31:0] LIM = 32'(4 * DM_WORDS);

  logic grant_cpu;
  logic grant_dma;
  logic cpu_ok;
  logic dma_ok;

  dm_arbiter_fsm #(
    .MAX_WAIT  (MAX_WAIT),
    .BURST_MAX (BURST_MAX)
  ) u_fsm (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .dma_valid (dma_valid),
    .grant_cpu (grant_cpu),
    .grant_dma (grant_dma)
  );

  assign cpu_ok    = in_range(cpu_addr, LIM);
  assign dma_ok    = in_range(dma_addr, LIM);
  assign cpu_stall = cpu_req & !grant_cpu;
  assign dma_ready = grant_dma;
  assign cpu_rdata = dm_rd;

  // DM port mux; CPU side is the idle default so reads stay defined
  always_comb begin
    dm_addr  = cpu_addr;
    dm_wdata = cpu_wdata;
    dm_we    = 1'b0;
    if (grant_dma) begin
      dm_addr  = dma_addr;
      dm_wdata = dma_wdata;
      dm_we    = dma_we & dma_ok;
    end else if (grant_cpu) begin
      dm_we = cpu_we & cpu_ok;
    end
  end

  // DMA response registered one cycle after each accepted beat
  always_ff @(posedge clk) begin
    if (reset) begin
      dma_rvalid <= 1'b0;
      dma_err    <= 1'b0;
      dma_rdata  <= 32'd0;
    end else begin
      dma_rvalid <= grant_dma;
      dma_err    <= grant_dma & !dma_ok;
      if (grant_dma && !dma_we && dma_ok)
        dma_rdata <= dm_rd;
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed vector table
// followed by randomized traffic against a behavioural model.
module tb_dm_arbiter;

  localparam int MAX_WAIT  = 4;
  localparam int BURST_MAX = 4;
  localparam int DM_WORDS  = 3072;
  localparam logic [31:0] LIM = 32'(4 * DM_WORDS);

  typedef struct packed {
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        dma_valid;
    logic        dma_we;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
  } stim_t;

  typedef struct packed {
    stim_t       s;
    logic        e_stall;
    logic        e_ready;
    logic        e_we;
    logic        e_rvalid;
    logic        e_err;
    logic [1:0]  kind;
    logic [31:0] e_rd;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dma_valid, dma_we;
  logic [31:0] dma_addr, dma_wdata;
  logic        dma_ready, dma_rvalid, dma_err;
  logic [31:0] dma_rdata;
  logic [31:0] dm_addr, dm_wdata, dm_rd;
  logic        dm_we;

  logic [31:0] mem [0:4095];
  logic [31:0] shadow [0:4095];

  int checks = 0;
  int errors = 0;

  bit          m_burst;
  int          m_refused;
  int          m_beats;
  bit          m_rvalid;
  bit          m_err;
  logic [31:0] m_rdata;

  logic        c_stall, c_ready, c_we, c_rvalid, c_err;
  logic [31:0] c_crd, c_drd;

  always #5 clk = ~clk;

  dm_arbiter #(
    .MAX_WAIT  (MAX_WAIT),
    .BURST_MAX (BURST_MAX),
    .DM_WORDS  (DM_WORDS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .dma_valid  (dma_valid),
    .dma_we     (dma_we),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_ready  (dma_ready),
    .dma_rvalid (dma_rvalid),
    .dma_rdata  (dma_rdata),
    .dma_err    (dma_err),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_we      (dm_we),
    .dm_rd      (dm_rd)
  );

  assign dm_rd = mem[dm_addr[13:2]];

  always @(posedge clk)
    if (dm_we) mem[dm_addr[13:2]] <= dm_wdata;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic inr(input logic [31:0] a);
    return a < LIM;
  endfunction

  task automatic model_reset();
    m_burst   = 0;
    m_refused = 0;
    m_beats   = 0;
    m_rvalid  = 0;
    m_err     = 0;
    m_rdata   = 32'd0;
  endtask

  // One clock of stimulus, checked against the model
  task automatic step(input stim_t s);
    logic        gd, gc, ewe;
    logic [31:0] eaddr, ewd, rd_before;
    @(negedge clk);
    reset     = s.rst;
    cpu_req   = s.cpu_req;
    cpu_we    = s.cpu_we;
    cpu_addr  = s.cpu_addr;
    cpu_wdata = s.cpu_wdata;
    dma_valid = s.dma_valid;
    dma_we    = s.dma_we;
    dma_addr  = s.dma_addr;
    dma_wdata = s.dma_wdata;
    #1;
    gd = s.dma_valid &&
         (m_burst || !s.cpu_req || m_refused >= MAX_WAIT);
    gc = s.cpu_req && !m_burst && !gd;
    eaddr = gd ? s.dma_addr : s.cpu_addr;
    ewd   = gd ? s.dma_wdata : s.cpu_wdata;
    ewe   = gd ? (s.dma_we && inr(s.dma_addr))
          : gc ? (s.cpu_we && inr(s.cpu_addr)) : 1'b0;
    chk("cpu_stall", 32'(cpu_stall), 32'(s.cpu_req && !gc));
    chk("dma_ready", 32'(dma_ready), 32'(gd));
    chk("dm_we", 32'(dm_we), 32'(ewe));
    chk("dm_addr", dm_addr, eaddr);
    if (ewe) chk("dm_wdata", dm_wdata, ewd);
    if (gc && !s.cpu_we && inr(s.cpu_addr))
      chk("cpu_rdata", cpu_rdata, shadow[s.cpu_addr[13:2]]);
    c_stall = cpu_stall;
    c_ready = dma_ready;
    c_we    = dm_we;
    c_crd   = cpu_rdata;
    @(posedge clk);
    rd_before = shadow[s.dma_addr[13:2]];
    if (ewe) shadow[eaddr[13:2]] = ewd;
    if (s.rst) begin
      model_reset();
    end else begin
      m_rvalid = gd;
      m_err    = gd && !inr(s.dma_addr);
      if (gd && !s.dma_we && inr(s.dma_addr))
        m_rdata = rd_before;
      if (m_burst) begin
        if (!s.dma_valid || m_beats + 1 >= BURST_MAX) begin
          m_burst   = 0;
          m_beats   = 0;
          m_refused = 0;
        end else begin
          m_beats++;
        end
      end else begin
        if (!s.dma_valid || gd) m_refused = 0;
        else if (m_refused < MAX_WAIT) m_refused++;
        if (gd && BURST_MAX > 1) begin
          m_burst = 1;
          m_beats = 1;
        end
      end
    end
    #1;
    chk("dma_rvalid", 32'(dma_rvalid), 32'(m_rvalid));
    if (m_rvalid) chk("dma_err", 32'(dma_err), 32'(m_err));
    chk("dma_rdata", dma_rdata, m_rdata);
    c_rvalid = dma_rvalid;
    c_err    = dma_err;
    c_drd    = dma_rdata;
  endtask

  function automatic vec_t mk(
    input logic rst, input logic cr, input logic cw,
    input logic [31:0] ca, input logic [31:0] cd,
    input logic dv, input logic dw,
    input logic [31:0] da, input logic [31:0] dd,
    input logic es, input logic er, input logic ew,
    input logic ev, input logic ee,
    input logic [1:0] k, input logic [31:0] erd);
    vec_t v;
    v.s = '{rst, cr, cw, ca, cd, dv, dw, da, dd};
    v.e_stall  = es;
    v.e_ready  = er;
    v.e_we     = ew;
    v.e_rvalid = ev;
    v.e_err    = ee;
    v.kind     = k;
    v.e_rd     = erd;
    return v;
  endfunction

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 7) == 0)
      return 32'($urandom_range(3064, 3080)) << 2;
    return 32'($urandom_range(0, 31)) << 2;
  endfunction

  vec_t  tbl[$];
  stim_t s, prev;
  logic  last_stall, last_ready;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i] <= 32'hA500_0000 | 32'(i);
      shadow[i] = 32'hA500_0000 | 32'(i);
    end
    mem[8] <= 32'h1234_5678;
    shadow[8] = 32'h1234_5678;
    model_reset();
    reset = 1'b1;
    {cpu_req, cpu_we, dma_valid, dma_we} = '0;
    {cpu_addr, cpu_wdata, dma_addr, dma_wdata} = '0;
    repeat (2) @(posedge clk);

    // reset state
    tbl.push_back(mk(1,0,0,0,0, 0,0,0,0, 0,0,0,0,0, 2,32'h0));
    // CPU store then load
    tbl.push_back(mk(0,1,1,32'h10,32'hDEADBEEF, 0,0,0,0,
                     0,0,1,0,0, 0,0));
    tbl.push_back(mk(0,1,0,32'h10,0, 0,0,0,0,
                     0,0,0,0,0, 1,32'hDEADBEEF));
    // starvation: DMA forced through on the fifth cycle
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0,1,0,32'h40,0, 1,0,32'h20,0,
                       0,0,0,0,0, 1,32'hA5000010));
    tbl.push_back(mk(0,1,0,32'h40,0, 1,0,32'h20,0,
                     1,1,0,1,0, 2,32'h12345678));
    tbl.push_back(mk(0,1,0,32'h40,0, 0,0,0,0,
                     1,0,0,0,0, 0,0));
    tbl.push_back(mk(0,1,0,32'h40,0, 0,0,0,0,
                     0,0,0,0,0, 1,32'hA5000010));
    // burst lock with a CPU request arriving in beat 2
    tbl.push_back(mk(0,0,0,0,0, 1,1,32'h0,32'h11,
                     0,1,1,1,0, 0,0));
    for (int i = 1; i < 4; i++)
      tbl.push_back(mk(0,1,0,32'h40,0, 1,1,32'(4*i),32'(17+i),
                       1,1,1,1,0, 0,0));
    tbl.push_back(mk(0,1,0,32'h40,0, 1,1,32'h10,32'h15,
                     0,0,0,0,0, 1,32'hA5000010));
    tbl.push_back(mk(0,0,0,0,0, 1,1,32'h10,32'h15,
                     0,1,1,1,0, 0,0));
    tbl.push_back(mk(0,0,0,0,0, 1,1,32'h14,32'h16,
                     0,1,1,1,0, 0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,0));
    // out-of-range accesses
    tbl.push_back(mk(0,0,0,0,0, 1,1,32'h3000,32'h77,
                     0,1,0,1,1, 2,32'h12345678));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,0));
    tbl.push_back(mk(0,1,1,32'h3000,32'h99, 0,0,0,0,
                     0,0,0,0,0, 0,0));
    // simultaneous request, CPU wins
    tbl.push_back(mk(0,1,0,32'h40,0, 1,0,32'h20,0,
                     0,0,0,0,0, 1,32'hA5000010));
    tbl.push_back(mk(0,0,0,0,0, 1,0,32'h20,0,
                     0,1,0,1,0, 2,32'h12345678));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,0));
    // reset in the middle of a burst
    tbl.push_back(mk(0,0,0,0,0, 1,0,32'h20,0,
                     0,1,0,1,0, 0,0));
    tbl.push_back(mk(0,0,0,0,0, 1,0,32'h24,0,
                     0,1,0,1,0, 0,0));
    tbl.push_back(mk(1,1,0,32'h40,0, 1,0,32'h28,0,
                     1,1,0,0,0, 2,32'h0));
    tbl.push_back(mk(0,1,0,32'h40,0, 0,0,0,0,
                     0,0,0,0,0, 1,32'hA5000010));

    foreach (tbl[i]) begin
      step(tbl[i].s);
      chk($sformatf("v%0d_stall", i), 32'(c_stall), 32'(tbl[i].e_stall));
      chk($sformatf("v%0d_ready", i), 32'(c_ready), 32'(tbl[i].e_ready));
      chk($sformatf("v%0d_we", i), 32'(c_we), 32'(tbl[i].e_we));
      chk($sformatf("v%0d_rvalid", i), 32'(c_rvalid), 32'(tbl[i].e_rvalid));
      if (tbl[i].e_rvalid)
        chk($sformatf("v%0d_err", i), 32'(c_err), 32'(tbl[i].e_err));
      if (tbl[i].kind == 2'd1)
        chk($sformatf("v%0d_crd", i), c_crd, tbl[i].e_rd);
      if (tbl[i].kind == 2'd2)
        chk($sformatf("v%0d_drd", i), c_drd, tbl[i].e_rd);
    end

    // randomized traffic obeying both hold rules
    prev = '0;
    last_stall = 1'b0;
    last_ready = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      s = prev;
      s.rst = ($urandom_range(0, 299) == 0);
      if (!(prev.cpu_req && last_stall)) begin
        s.cpu_req   = ($urandom_range(0, 2) != 0);
        s.cpu_we    = $urandom_range(0, 1) == 1;
        s.cpu_addr  = rand_addr();
        s.cpu_wdata = $urandom;
      end
      if (!(prev.dma_valid && !last_ready)) begin
        s.dma_valid = ($urandom_range(0, 3) != 0);
        s.dma_we    = $urandom_range(0, 1) == 1;
        s.dma_addr  = rand_addr();
        s.dma_wdata = $urandom;
      end
      step(s);
      last_stall = c_stall;
      last_ready = c_ready;
      prev = s;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Shares the single-ported data memory between two requesters: the pipeline M stage (CPU) and a word-wide DMA/loader port.
- Placed between the M-stage memory signals and the DM instance, and drives the DM's address, write-data and write-enable inputs.
- CPU has priority by default. A starvation counter forces a DMA grant, and a burst lock keeps the DMA granted for consecutive beats.
- CPU loses its slot only through cpu_stall, which the hazard unit ORs into the pipeline freeze.

Parameters:
MAX_WAIT, 4, cycles a pending DMA request may be refused before it is force-granted (1..15)
BURST_MAX, 4, maximum consecutive DMA beats per ownership period (1..15)
DM_WORDS, 3072, DM depth in words; legal byte addresses are 0 .. 4*DM_WORDS-1

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
cpu_req  in  1  M stage performs a load or store this cycle
cpu_we  in  1  store when 1
cpu_addr  in  32  byte address (word-aligned)
cpu_wdata  in  32  store data
cpu_rdata  out  32  load data, combinational from dm_rd
cpu_stall  out  1  CPU access not performed this cycle; hold M stage
dma_valid  in  1  DMA beat pending; addr/we/wdata stable while valid & !ready
dma_we  in  1  DMA write when 1
dma_addr  in  32  DMA byte address
dma_wdata  in  32  DMA write data
dma_ready  out  1  beat accepted this cycle (handshake = valid & ready)
dma_rvalid  out  1  one-cycle pulse, cycle after any accepted beat
dma_rdata  out  32  read data for the accepted read beat; holds until the next rvalid
dma_err  out  1  qualifies dma_rvalid: the beat's address was out of range
dm_addr  out  32  to DM address
dm_wdata  out  32  to DM write data
dm_we  out  1  to DM write enable
dm_rd  in  32  DM combinational read data

Behaviour:
- States (2 bits): CPU_PRI, DMA_OWN. Registers: wait_cnt[3:0], beat_cnt[3:0].
- Reset (sync): state=CPU_PRI, wait_cnt=0, beat_cnt=0, dma_rvalid=0, dma_err=0, dma_rdata=0. An in-flight beat is dropped and no rvalid is produced.
- Grant in CPU_PRI (combinational):
  - grant_dma = dma_valid & (!cpu_req | wait_cnt==MAX_WAIT).
  - grant_cpu = cpu_req & !grant_dma.
- Grant in DMA_OWN: grant_dma = dma_valid; grant_cpu = 0.
- cpu_stall = cpu_req & !grant_cpu. dma_ready = grant_dma.
- DM mux:
  - If grant_dma: dm_addr=dma_addr, dm_wdata=dma_wdata.
  - Otherwise: dm_addr=cpu_addr, dm_wdata=cpu_wdata. This also applies when idle, so the read path is always defined.
- dm_we = the granted requester's we & addr < 4*DM_WORDS. Out-of-range writes are suppressed silently for the CPU.
- cpu_rdata = dm_rd. Zero-latency load, matching the existing M-stage timing.
- wait_cnt in CPU_PRI:
  - Increments, saturating at MAX_WAIT, when dma_valid & !grant_dma.
  - Clears on grant_dma or when dma_valid=0.
- State transitions:
  - CPU_PRI -> DMA_OWN on grant_dma with BURST_MAX>1; beat_cnt becomes 1.
  - DMA_OWN increments beat_cnt per accepted beat.
  - DMA_OWN -> CPU_PRI when dma_valid=0, or when a beat is accepted with beat_cnt==BURST_MAX-1. On exit, beat_cnt and wait_cnt are cleared.
  - With BURST_MAX=1 the arbiter stays in CPU_PRI.
- DMA response, registered on the cycle after any accepted beat:
  - dma_rvalid=1 for that single cycle.
  - dma_err = address out of range.
  - dma_rdata = the dm_rd value sampled on the accept edge if the beat was an in-range read; otherwise it is unchanged.
- Simultaneous cpu_req & dma_valid with wait_cnt<MAX_WAIT: CPU wins, DMA waits.
- A CPU stalled in DMA_OWN keeps cpu_req high. It is served in the first CPU_PRI cycle, because wait_cnt=0 gives it priority there.
- Worst-case CPU stall = BURST_MAX cycles per DMA ownership period. Guaranteed DMA latency ≤ MAX_WAIT+1 cycles.

Decomposition:
- Shared package holds: state encoding (CPU_PRI=2'd0, DMA_OWN=2'd1), DM_BYTES = 4*DM_WORDS, and an in_range(addr) function used by both paths.
- No sub-module is natural beyond an optional dm_arb_fsm holding state, wait_cnt and beat_cnt. The muxing stays in the top level.

Test Plan:
- CPU-only: cpu_req=1, cpu_we=1, addr 0x10, data 0xDEADBEEF; next cycle a load from 0x10 -> dm_we=1 in the first cycle, cpu_rdata=0xDEADBEEF in the second, cpu_stall=0 throughout.
- Starvation: cpu_req held 1, dma_valid=1 read at 0x20 (DM holds 0x12345678), MAX_WAIT=4 -> dma_ready first asserts in cycle 5, cpu_stall=1 that cycle, dma_rvalid in cycle 6 with dma_rdata=0x12345678.
- Burst lock: CPU idle, DMA streams 6 writes to 0x0,0x4,…, BURST_MAX=4 -> 4 consecutive accepts; a cpu_req raised in beat 2 is stalled until state returns to CPU_PRI (cycle 5), then granted; DMA resumes afterwards.
- Out-of-range: DMA write to 0x3000 -> dma_ready=1, dm_we=0, next cycle dma_rvalid=1, dma_err=1, dma_rdata unchanged; CPU store to 0x3000 -> dm_we=0, cpu_stall=0.
- Reset mid-burst: reset in DMA_OWN after 2 beats -> next cycle state CPU_PRI, dma_rvalid=0, dma_rdata=0, and a pending cpu_req is granted immediately.
- Simultaneous, no starvation: cpu_req & dma_valid, both for 1 cycle, wait_cnt=0 -> CPU granted, dma_ready=0, and wait_cnt=1 on the next cycle if dma_valid is held.
